// File: rtl/uart_packet_tx.sv
// Packet framer: latches a 3-byte header plus payload, then feeds the UART one byte
// at a time over the trmt/tx_data/tx_done handshake, pausing between bytes while tx_en is low.
module uart_packet_tx #(
    parameter int PAYLOAD_BYTES = 18,
    parameter int HDR_BYTES     = 3,
    localparam int N            = HDR_BYTES + PAYLOAD_BYTES,
    localparam int IDX_W        = (N > 1) ? $clog2(N) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [7:0]                 cmd,
    input  logic [15:0]                tag,
    input  logic [8*PAYLOAD_BYTES-1:0] payload,
    input  logic                       tx_en,
    input  logic                       tx_done,
    output logic                       trmt,
    output logic [7:0]                 tx_data,
    output logic                       busy,
    output logic                       done,
    output logic [IDX_W-1:0]           byte_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [7:0]       shadow_r [N];
    logic [7:0]       tx_data_r;
    logic             busy_r;
    logic             done_r;
    logic             first_wait_r;
    logic [IDX_W-1:0] byte_idx_r;
    logic [IDX_W-1:0] idx_inc_s;
    logic             accept_s;
    logic             launch_s;
    logic             advance_s;
    logic             finish_s;

    assign idx_inc_s = byte_idx_r + IDX_W'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        launch_s    = 1'b0;
        advance_s   = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_ARM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (tx_en) begin
                    launch_s    = 1'b1;
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ARM;
                end
            end
            ST_WAIT: begin
                // tx_done may still be stale from the previous byte in the first WAIT cycle
                if (!first_wait_r && tx_done) begin
                    if (byte_idx_r == LAST_IDX) begin
                        finish_s    = 1'b1;
                        state_nxt_s = ST_FIN;
                    end else begin
                        advance_s   = 1'b1;
                        state_nxt_s = ST_ARM;
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_FIN: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Shadow buffer, byte index, presented byte and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                shadow_r[i] <= 8'h00;
            end
            tx_data_r    <= 8'h00;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            first_wait_r <= 1'b0;
            byte_idx_r   <= '0;
        end else begin
            if (accept_s) begin
                shadow_r[0] <= cmd;
                shadow_r[1] <= tag[7:0];
                shadow_r[2] <= tag[15:8];
                for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                    shadow_r[HDR_BYTES + i] <= payload[8*i +: 8];
                end
                tx_data_r  <= cmd;
                busy_r     <= 1'b1;
                byte_idx_r <= '0;
            end else if (advance_s) begin
                tx_data_r  <= shadow_r[idx_inc_s];
                byte_idx_r <= idx_inc_s;
            end else if (finish_s) begin
                busy_r     <= 1'b0;
                byte_idx_r <= '0;
            end else begin
                byte_idx_r <= byte_idx_r;
            end
            done_r       <= finish_s;
            first_wait_r <= launch_s;
        end
    end

    // The launch strobe is the ARM-cycle decision itself, giving one-cycle start latency
    assign trmt     = launch_s;
    assign tx_data  = tx_data_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign byte_idx = byte_idx_r;

endmodule
